// File: rtl/eth_cmd_pkg.sv
// Shared types, constants and small helpers for the Ethernet command receive path.
package eth_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    PAYLOAD  = 3'd3,
    CHECK    = 3'd4,
    DROP     = 3'd5
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam int          MIN_LEN       = 64;
  localparam logic [47:0] BCAST         = 48'hFFFF_FFFF_FFFF;

  localparam logic [7:0] OP_ARM   = 8'h01;
  localparam logic [7:0] OP_START = 8'h02;
  localparam logic [7:0] OP_STOP  = 8'h03;

  // Byte idx of a MAC address in wire order (idx 0 is the first byte sent).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      3'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_cmd_rx_if.sv
// Byte-stream input and decoded-command/status output bundle of the command receiver.
interface eth_cmd_rx_if;
  logic [7:0]  rx_data;
  logic        rx_dv;
  logic        rx_er;
  logic        cmd_valid;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        busy;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  modport master (
    output rx_data, rx_dv, rx_er,
    input  cmd_valid, cmd_op, cmd_arg, busy, good_cnt, bad_cnt
  );

  modport slave (
    input  rx_data, rx_dv, rx_er,
    output cmd_valid, cmd_op, cmd_arg, busy, good_cnt, bad_cnt
  );
endinterface

// File: rtl/crc32_d8.sv
// Combinational IEEE 802.3 reflected CRC-32 update for one byte, LSB of d first.
module crc32_d8
  import eth_cmd_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  logic [31:0] c_s;

  // Eight serial shift steps unrolled into one byte per clock.
  always_comb begin
    c_s = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c_s[0] ^ d[i]) begin
        c_s = (c_s >> 1) ^ CRC_POLY_REFL;
      end else begin
        c_s = c_s >> 1;
      end
    end
    crc_out = c_s;
  end

endmodule

// File: rtl/eth_cmd_rx.sv
// Receive-side command frame decoder: parses RGMII bytes, filters DA/EtherType,
// checks length and FCS, and emits one opcode + argument per good frame.
module eth_cmd_rx
  import eth_cmd_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR  = 48'h000A_3500_0102,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          MAX_LEN   = 1518
) (
  input  logic        clk,
  input  logic        rst,
  eth_cmd_rx_if.slave bus
);

  rx_state_e   state_r;
  logic        busy_r;
  logic [10:0] byte_cnt_r;
  logic [2:0]  pre_cnt_r;
  logic [31:0] crc_r;
  logic        err_r;
  logic        silent_r;
  logic        seen_idle_r;
  logic        ucast_r;
  logic        bcast_r;
  logic [7:0]  op_shadow_r;
  logic [31:0] arg_shadow_r;
  logic        cmd_valid_r;
  logic [7:0]  cmd_op_r;
  logic [31:0] cmd_arg_r;
  logic [15:0] good_cnt_r;
  logic [15:0] bad_cnt_r;

  logic [31:0] crc_next_s;
  logic [10:0] byte_cnt_inc_s;
  logic        ucast_hit_s;
  logic        bcast_hit_s;
  logic [7:0]  et_byte_s;
  logic        frame_ok_s;

  crc32_d8 u_crc (
    .crc_in  (crc_r),
    .d       (bus.rx_data),
    .crc_out (crc_next_s)
  );

  // Per-byte address/EtherType matches and the end-of-frame verdict.
  always_comb begin
    ucast_hit_s = ucast_r && (bus.rx_data == mac_byte(MAC_ADDR, byte_cnt_r[2:0]));
    bcast_hit_s = bcast_r && (bus.rx_data == mac_byte(BCAST, byte_cnt_r[2:0]));
    if (byte_cnt_r[0]) begin
      et_byte_s = ETHERTYPE[7:0];
    end else begin
      et_byte_s = ETHERTYPE[15:8];
    end
    byte_cnt_inc_s = (byte_cnt_r == 11'h7FF) ? byte_cnt_r : byte_cnt_r + 11'd1;
    // The reflected register holds the residue bit-reversed relative to the MSB-first constant.
    frame_ok_s = (bit_rev32(crc_r) == CRC_RESIDUE) &&
                 (byte_cnt_r >= 11'(MIN_LEN)) &&
                 (byte_cnt_r <= 11'(MAX_LEN)) &&
                 !err_r;
  end

  // Frame parser FSM with registered command and counter outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      byte_cnt_r   <= 11'd0;
      pre_cnt_r    <= 3'd0;
      crc_r        <= 32'hFFFF_FFFF;
      err_r        <= 1'b0;
      silent_r     <= 1'b0;
      seen_idle_r  <= 1'b0;
      ucast_r      <= 1'b0;
      bcast_r      <= 1'b0;
      op_shadow_r  <= 8'h00;
      arg_shadow_r <= 32'h0000_0000;
      cmd_valid_r  <= 1'b0;
      cmd_op_r     <= 8'h00;
      cmd_arg_r    <= 32'h0000_0000;
      good_cnt_r   <= 16'h0000;
      bad_cnt_r    <= 16'h0000;
    end else begin
      cmd_valid_r <= 1'b0;
      if (bus.rx_dv && bus.rx_er &&
          ((state_r == PREAMBLE) || (state_r == HEADER) || (state_r == PAYLOAD))) begin
        err_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          // After reset the tail of an interrupted frame must pass before arming.
          if (!seen_idle_r) begin
            seen_idle_r <= !bus.rx_dv;
          end else if (bus.rx_dv) begin
            state_r   <= PREAMBLE;
            busy_r    <= 1'b1;
            pre_cnt_r <= 3'd1;
            err_r     <= 1'b0;
            silent_r  <= 1'b0;
          end
        end

        PREAMBLE: begin
          if (!bus.rx_dv) begin
            bad_cnt_r <= sat_inc16(bad_cnt_r);
            state_r   <= IDLE;
            busy_r    <= 1'b0;
          end else if (bus.rx_data == SFD_BYTE) begin
            state_r    <= HEADER;
            byte_cnt_r <= 11'd0;
            crc_r      <= 32'hFFFF_FFFF;
            ucast_r    <= 1'b1;
            bcast_r    <= 1'b1;
          end else if ((bus.rx_data == PREAMBLE_BYTE) && (pre_cnt_r != 3'd7)) begin
            pre_cnt_r <= pre_cnt_r + 3'd1;
          end else begin
            state_r <= DROP;
          end
        end

        HEADER: begin
          if (!bus.rx_dv) begin
            bad_cnt_r <= sat_inc16(bad_cnt_r);
            state_r   <= IDLE;
            busy_r    <= 1'b0;
          end else begin
            byte_cnt_r <= byte_cnt_inc_s;
            crc_r      <= crc_next_s;
            if (byte_cnt_r < 11'd6) begin
              ucast_r <= ucast_hit_s;
              bcast_r <= bcast_hit_s;
              if (!ucast_hit_s && !bcast_hit_s) begin
                silent_r <= 1'b1;
                state_r  <= DROP;
              end
            end else if (byte_cnt_r >= 11'd12) begin
              if (bus.rx_data != et_byte_s) begin
                silent_r <= 1'b1;
                state_r  <= DROP;
              end else if (byte_cnt_r == 11'd13) begin
                state_r <= PAYLOAD;
              end
            end
          end
        end

        PAYLOAD: begin
          if (!bus.rx_dv) begin
            state_r <= CHECK;
          end else if (byte_cnt_r >= 11'(MAX_LEN)) begin
            state_r <= DROP;
          end else begin
            byte_cnt_r <= byte_cnt_inc_s;
            crc_r      <= crc_next_s;
            if (byte_cnt_r == 11'd14) begin
              op_shadow_r <= bus.rx_data;
            end
            if ((byte_cnt_r >= 11'd15) && (byte_cnt_r <= 11'd18)) begin
              arg_shadow_r <= {arg_shadow_r[23:0], bus.rx_data};
            end
          end
        end

        CHECK: begin
          if (frame_ok_s) begin
            cmd_valid_r <= 1'b1;
            cmd_op_r    <= op_shadow_r;
            cmd_arg_r   <= arg_shadow_r;
            good_cnt_r  <= sat_inc16(good_cnt_r);
          end else begin
            bad_cnt_r <= sat_inc16(bad_cnt_r);
          end
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end

        DROP: begin
          if (!bus.rx_dv) begin
            if (!silent_r) begin
              bad_cnt_r <= sat_inc16(bad_cnt_r);
            end
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end

        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_valid = cmd_valid_r;
  assign bus.cmd_op    = cmd_op_r;
  assign bus.cmd_arg   = cmd_arg_r;
  assign bus.busy      = busy_r;
  assign bus.good_cnt  = good_cnt_r;
  assign bus.bad_cnt   = bad_cnt_r;

endmodule

// File: tb/tb_eth_cmd_rx.sv
// Directed bench for eth_cmd_rx: a frame-level model predicts verdicts, counters and
// command outputs, and a per-cycle compare process checks the DUT against it.
module tb_eth_cmd_rx;

  localparam logic [47:0] MAC   = 48'h000A_3500_0102;
  localparam logic [47:0] BC    = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETYPE = 16'h88B5;
  localparam int          MAXL  = 1518;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  eth_cmd_rx_if bus();

  eth_cmd_rx #(.MAC_ADDR(MAC), .ETHERTYPE(ETYPE), .MAX_LEN(MAXL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          when_cyc;
    bit          good;
    logic [7:0]  op;
    logic [31:0] arg;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] frame_q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && bus.cmd_valid) pulses <= pulses + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Frame from DA through FCS, zero-ish padding, FCS sent least significant byte first.
  task automatic build_frame(input logic [47:0] da, input logic [15:0] et,
                             input logic [7:0] op, input logic [31:0] arg, input int n_total);
    logic [31:0] c;
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frame_q.push_back((i == 5) ? 8'h01 : 8'h02 - 8'(i != 0) * 8'h02);
    frame_q.push_back(et[15:8]);
    frame_q.push_back(et[7:0]);
    frame_q.push_back(op);
    for (int i = 0; i < 4; i++) frame_q.push_back(arg[31-8*i -: 8]);
    for (int i = frame_q.size(); i < n_total - 4; i++) frame_q.push_back(8'(i));
    c = 32'hFFFF_FFFF;
    foreach (frame_q[i]) c = crc_step(c, frame_q[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frame_q.push_back(c[8*i +: 8]);
  endtask

  // Frame-level verdict: filtered frames leave no trace, long frames are rejected when
  // rx_dv falls, everything else is judged one cycle later.
  function automatic void model_frame(input int last_cyc, input bit er);
    int          n;
    logic [47:0] da;
    logic [15:0] et;
    logic [31:0] c;
    logic [31:0] fcs;
    ev_t         e;
    n  = frame_q.size();
    da = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
    et = {frame_q[12], frame_q[13]};
    if ((da != MAC) && (da != BC)) return;
    if (et != ETYPE) return;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n - 4; i++) c = crc_step(c, frame_q[i]);
    fcs   = {frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]};
    e.op  = frame_q[14];
    e.arg = {frame_q[15], frame_q[16], frame_q[17], frame_q[18]};
    if (n > MAXL) begin
      e.good     = 1'b0;
      e.when_cyc = last_cyc + 1;
    end else begin
      e.good     = (fcs == ~c) && (n >= 64) && !er;
      e.when_cyc = last_cyc + 2;
    end
    ev_q.push_back(e);
  endfunction

  task automatic send_preamble(input bit chk_busy);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.rx_dv   = 1'b1;
      bus.rx_er   = 1'b0;
      bus.rx_data = (i == 7) ? 8'hD5 : 8'h55;
      if (chk_busy && i == 3) begin
        @(negedge clk);
        chk("busy_mid_frame", 32'(bus.busy), 32'h1);
      end
    end
  endtask

  task automatic end_frame(input int gap);
    @(posedge clk); #1;
    bus.rx_dv   = 1'b0;
    bus.rx_er   = 1'b0;
    bus.rx_data = 8'h00;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic send_frame(input int gap, input int er_at, input bit chk_busy);
    send_preamble(chk_busy);
    for (int i = 0; i < frame_q.size(); i++) begin
      @(posedge clk); #1;
      bus.rx_data = frame_q[i];
      bus.rx_er   = (i == er_at);
    end
    model_frame(cyc + 1, er_at >= 0);
    end_frame(gap);
  endtask

  // Reset pulse lands while the DA is being parsed; the tail still streams in afterwards.
  task automatic send_frame_with_reset(input int gap);
    send_preamble(1'b0);
    for (int i = 0; i < frame_q.size(); i++) begin
      @(posedge clk); #1;
      bus.rx_data = frame_q[i];
      if (i == 5) rst = 1'b1;
      if (i == 7) rst = 1'b0;
    end
    end_frame(gap);
  endtask

  // Per-cycle compare of every output against the model's expectations.
  initial begin : compare
    logic        ev_v;
    logic [7:0]  eo;
    logic [31:0] ea;
    logic [15:0] eg;
    logic [15:0] eb;
    eo = 8'h00; ea = 32'h0; eg = 16'h0; eb = 16'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        eo = 8'h00; ea = 32'h0; eg = 16'h0; eb = 16'h0;
        ev_q.delete();
      end else begin
        ev_v = 1'b0;
        while (ev_q.size() > 0 && ev_q[0].when_cyc <= cyc) begin
          if (ev_q[0].good) begin
            ev_v = 1'b1;
            eo   = ev_q[0].op;
            ea   = ev_q[0].arg;
            eg   = (eg == 16'hFFFF) ? eg : eg + 16'd1;
          end else begin
            eb = (eb == 16'hFFFF) ? eb : eb + 16'd1;
          end
          void'(ev_q.pop_front());
        end
        chk("cyc_cmd_valid", 32'(bus.cmd_valid), 32'(ev_v));
        chk("cyc_cmd_op", 32'(bus.cmd_op), 32'(eo));
        chk("cyc_cmd_arg", bus.cmd_arg, ea);
        chk("cyc_good_cnt", 32'(bus.good_cnt), 32'(eg));
        chk("cyc_bad_cnt", 32'(bus.bad_cnt), 32'(eb));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    string       s;
    logic [31:0] c;
    bus.rx_data = 8'h00;
    bus.rx_dv   = 1'b0;
    bus.rx_er   = 1'b0;

    s = "123456789";
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) c = crc_step(c, s[i]);
    chk("model_crc_check_value", ~c, 32'hCBF43926);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'h0);
    chk("rst_cmd_op", 32'(bus.cmd_op), 32'h0);
    chk("rst_cmd_arg", bus.cmd_arg, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_good_cnt", 32'(bus.good_cnt), 32'h0);
    chk("rst_bad_cnt", 32'(bus.bad_cnt), 32'h0);
    repeat (3) @(posedge clk);

    build_frame(MAC, ETYPE, 8'h02, 32'hDEADBEEF, 64);
    send_frame(5, -1, 1'b1);
    @(negedge clk);
    chk("good_op", 32'(bus.cmd_op), 32'h02);
    chk("good_arg", bus.cmd_arg, 32'hDEADBEEF);
    chk("good_cnt_1", 32'(bus.good_cnt), 32'h1);
    chk("good_busy_after", 32'(bus.busy), 32'h0);

    build_frame(MAC, ETYPE, 8'h02, 32'hDEADBEEF, 64);
    frame_q[16] = frame_q[16] ^ 8'h01;
    send_frame(5, -1, 1'b0);
    @(negedge clk);
    chk("crcerr_bad_cnt", 32'(bus.bad_cnt), 32'h1);
    chk("crcerr_op_held", 32'(bus.cmd_op), 32'h02);
    chk("crcerr_arg_held", bus.cmd_arg, 32'hDEADBEEF);

    build_frame(48'h0200_0000_0099, ETYPE, 8'h02, 32'h1, 64);
    send_frame(5, -1, 1'b0);
    build_frame(MAC, 16'h0800, 8'h02, 32'h1, 64);
    send_frame(5, -1, 1'b0);
    @(negedge clk);
    chk("filter_good_cnt", 32'(bus.good_cnt), 32'h1);
    chk("filter_bad_cnt", 32'(bus.bad_cnt), 32'h1);

    build_frame(BC, ETYPE, 8'h01, 32'h0000_0010, 64);
    send_frame(1, -1, 1'b0);
    build_frame(MAC, ETYPE, 8'h03, 32'h1234_5678, 64);
    send_frame(5, -1, 1'b0);
    @(negedge clk);
    chk("b2b_good_cnt", 32'(bus.good_cnt), 32'h3);
    chk("b2b_op", 32'(bus.cmd_op), 32'h03);
    chk("b2b_arg", bus.cmd_arg, 32'h1234_5678);
    chk("b2b_pulses", 32'(pulses), 32'h3);

    build_frame(MAC, ETYPE, 8'h01, 32'h0, 40);
    send_frame(5, -1, 1'b0);
    @(negedge clk);
    chk("runt_busy", 32'(bus.busy), 32'h0);
    chk("runt_bad_cnt", 32'(bus.bad_cnt), 32'h2);
    build_frame(MAC, ETYPE, 8'h01, 32'h0, 64);
    send_frame(5, 30, 1'b0);
    @(negedge clk);
    chk("rxer_busy", 32'(bus.busy), 32'h0);
    chk("rxer_bad_cnt", 32'(bus.bad_cnt), 32'h3);
    build_frame(MAC, ETYPE, 8'h01, 32'h0, 1600);
    send_frame(5, -1, 1'b0);
    @(negedge clk);
    chk("long_busy", 32'(bus.busy), 32'h0);
    chk("long_bad_cnt", 32'(bus.bad_cnt), 32'h4);
    chk("long_good_cnt", 32'(bus.good_cnt), 32'h3);

    build_frame(MAC, ETYPE, 8'h02, 32'h5555_AAAA, 64);
    send_frame_with_reset(3);
    @(negedge clk);
    chk("rstmid_bad_cnt", 32'(bus.bad_cnt), 32'h0);
    chk("rstmid_good_cnt", 32'(bus.good_cnt), 32'h0);
    chk("rstmid_busy", 32'(bus.busy), 32'h0);
    build_frame(MAC, ETYPE, 8'h01, 32'hCAFE_F00D, 64);
    send_frame(5, -1, 1'b0);
    @(negedge clk);
    chk("after_rst_good_cnt", 32'(bus.good_cnt), 32'h1);
    chk("after_rst_op", 32'(bus.cmd_op), 32'h01);
    chk("after_rst_arg", bus.cmd_arg, 32'hCAFE_F00D);

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/eth_cmd_rx.md
# eth_cmd_rx

Receive-side command decoder for the gigabit Ethernet link, in the 125 MHz clock domain alongside the capture transmitter. It takes the byte stream delivered by the RGMII receive path and parses Ethernet frames carrying the team's command EtherType. It validates the destination MAC, length and FCS, then emits one decoded command (opcode + 32-bit argument) per good frame. Downstream, commands drive capture start/arming in place of the push-button, plus housekeeping counters.

## Interface
Parameters:
- MAC_ADDR, 48'h000A_3500_0102: station address; frames addressed here or to broadcast FF:FF:FF:FF:FF:FF are accepted.
- ETHERTYPE, 16'h88B5: command EtherType (IEEE local experimental).
- MAX_LEN, 1518: maximum frame length in bytes, destination MAC through FCS inclusive.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  125 MHz receive byte clock.
- rst  in  1  asynchronous active-high reset.
- rx_data  in  8  received byte, valid when rx_dv=1.
- rx_dv  in  1  frame data valid; high from first preamble byte through last FCS byte.
- rx_er  in  1  receive error flag from the PHY, qualified by rx_dv.
- cmd_valid  out  1  one-cycle pulse: good command frame decoded.
- cmd_op  out  8  opcode, held until the next cmd_valid.
- cmd_arg  out  32  argument, big-endian on the wire, held until the next cmd_valid.
- busy  out  1  high while a frame is being parsed (any state other than IDLE).
- good_cnt  out  16  count of accepted frames, saturating at FFFF.
- bad_cnt  out  16  count of rejected frames (address/EtherType mismatch excluded), saturating.

## Operation
- Frame layout after SFD:
  - DA[6], SA[6], EtherType[2], opcode[1], arg[4] MSB first.
  - Pad to a 60-byte minimum.
  - FCS[4].
- States and transitions:
  - IDLE: wait for rx_dv=1, then go to PREAMBLE.
  - PREAMBLE: accept bytes 0x55. Byte 0xD5 goes to HEADER and clears the byte counter and CRC (seed FFFFFFFF). Any other byte, or more than 7 preamble bytes, goes to DROP.
  - HEADER: bytes 0–13. Compare DA byte-by-byte against MAC_ADDR and broadcast; compare bytes 12–13 against ETHERTYPE. On a mismatch set a silent flag and go to DROP. A silent drop does not increment bad_cnt.
  - PAYLOAD: capture opcode from byte 14 and arg from bytes 15–18 into shadow registers. Stay here until rx_dv falls.
  - CHECK: entered on the first cycle with rx_dv=0. The frame is good when all of the following hold:
    - CRC residue equals C704DD7B;
    - byte count is ≥64 and ≤MAX_LEN;
    - no rx_er was seen.
    - Good frame: copy shadows to cmd_op/cmd_arg, pulse cmd_valid, increment good_cnt.
    - Otherwise increment bad_cnt.
    - Always return to IDLE.
  - DROP: wait for rx_dv=0. Increment bad_cnt unless the silent flag is set, then go to IDLE.
- rx_er=1 with rx_dv=1 in any parsing state sets the error flag. The frame is then counted bad in CHECK.
- Byte count above MAX_LEN: go to DROP immediately; the frame is counted bad.
- Byte counter is 11 bits and saturates at 2047.
- CRC: IEEE 802.3 reflected CRC-32, one byte per clock, computed over DA through FCS.
- rx_dv falling in PREAMBLE or HEADER (runt): counted bad and returns to IDLE.
- Reset values: cmd_valid=0, cmd_op=0, cmd_arg=0, busy=0, good_cnt=0, bad_cnt=0; state IDLE.
- Reset mid-frame: the block returns to IDLE. The remainder of the in-flight frame is ignored because IDLE waits for rx_dv to fall first: a `seen_idle` flag, cleared by reset, must observe rx_dv=0 before the next frame is accepted.

## Timing
- All outputs are registered.
- cmd_valid asserts exactly 1 cycle after the first clk edge sampling rx_dv=0 following the last FCS byte, i.e. 2 cycles after the last byte.
- cmd_op/cmd_arg change only on the same cycle as cmd_valid.
- Counters update on the cycle the verdict is reached.
- Back-to-back frames with a minimum 1-cycle rx_dv gap must all be decoded; there is no throughput loss.
- busy rises the cycle after rx_dv is first sampled high and falls with the return to IDLE.

## Structure
- Package eth_cmd_pkg holds:
  - state enum (IDLE, PREAMBLE, HEADER, PAYLOAD, CHECK, DROP);
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_RESIDUE=32'hC704DD7B, MIN_LEN=64, BCAST=48'hFFFF_FFFF_FFFF;
  - opcode constants OP_ARM=8'h01, OP_START=8'h02, OP_STOP=8'h03.
- One sub-module, crc32_d8: combinational next-CRC for one byte (crc_in[31:0], d[7:0] to crc_out[31:0]), reused by the transmit side.

## Test plan
- Good unicast frame, DA=MAC_ADDR, op=02, arg=DEADBEEF, 64 bytes, valid FCS -> cmd_valid pulse 2 cycles after last byte; cmd_op=02, cmd_arg=DEADBEEF; good_cnt=1.
- Same frame with one payload byte flipped -> no cmd_valid; bad_cnt=1; cmd_op/cmd_arg keep previous values.
- Frame to other MAC 02:00:00:00:00:99, and a frame with EtherType 0800 -> no cmd_valid; good_cnt and bad_cnt unchanged.
- Broadcast frame op=01, arg=00000010, followed after a 1-cycle gap by unicast op=03 -> two cmd_valid pulses in order; good_cnt=2.
- Runt (40 bytes, valid CRC), rx_er pulse mid-payload, and a 1600-byte frame -> each rejected; bad_cnt=3; busy low after each.
- Assert rst during HEADER of a frame, release while rx_dv is still high -> that frame is ignored; the next good frame is decoded normally.
